// File: rtl/dm_arb_pkg.sv
// Shared constants and the id-width helper for the data-memory arbiter.
// Optional com-fairness logic is enabled by defining DM_ARB_FAIRNESS_EN.
package dm_arb_pkg;

  // Width of an id that can name every core plus the com port.
  function automatic int unsigned id_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned NUM_C_DEF = 4;
  localparam int unsigned COM_ID    = NUM_C_DEF;
  localparam int unsigned ID_W_DEF  = id_w(NUM_C_DEF);

endpackage

// File: rtl/dm_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first set request at or after
// i_ptr, wrapping from N-1 to 0.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);

  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_j = PW'((32'(i_ptr) + i) % N);
      if (!o_any && i_req[w_j]) begin
        o_any        = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
      end
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the data memory between NUM_C cores (round-robin) and the
// com port (priority). Define DM_ARB_FAIRNESS_EN to bound consecutive com grants.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned NUM_C  = NUM_C_DEF,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
`ifdef DM_ARB_FAIRNESS_EN
  ,
  parameter int unsigned COM_MAX = 4
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_C-1:0]          core_en,
  input  logic [NUM_C-1:0]          core_req,
  input  logic [NUM_C-1:0]          core_wr_en,
  input  logic [NUM_C*ADDR_W-1:0]   core_addr,
  input  logic [NUM_C*DATA_W-1:0]   core_data_in,
  output logic [NUM_C-1:0]          core_grant,
  input  logic                      com_req,
  input  logic                      com_wr_en,
  input  logic [ADDR_W-1:0]         com_addr,
  input  logic [DATA_W-1:0]         com_data_in,
  output logic                      com_grant,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_data_in,
  output logic                      mem_wr_en,
  input  logic [DATA_W-1:0]         mem_data_out,
  output logic                      rd_valid,
  output logic [id_w(NUM_C)-1:0]    rd_id,
  output logic [DATA_W-1:0]         rd_data
);

  localparam int unsigned PW   = $clog2(NUM_C);
  localparam int unsigned ID_W = id_w(NUM_C);

  logic [NUM_C-1:0] w_req;
  logic [NUM_C-1:0] w_pick_gnt;
  logic [PW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic             w_com_win;
  logic             w_core_win;
  logic             w_gnt_rd;
  logic [ID_W-1:0]  w_gnt_id;

  logic [PW-1:0]    r_rr_ptr;
  logic             r_rd_valid;
  logic [ID_W-1:0]  r_rd_id;

  assign w_req = core_req & core_en;

  rr_pick #(.N(NUM_C)) u_rr_pick (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

`ifdef DM_ARB_FAIRNESS_EN
  localparam int unsigned SW = $clog2(COM_MAX + 1);

  logic [SW-1:0] r_com_streak;
  logic          w_force_core;

  // A saturated com streak yields one cycle to a waiting core.
  assign w_force_core = (r_com_streak == SW'(COM_MAX)) && w_pick_any;
  assign w_com_win    = com_req && !w_force_core && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_com_streak <= '0;
    end else if (w_com_win) begin
      if (r_com_streak != SW'(COM_MAX)) r_com_streak <= r_com_streak + 1'b1;
    end else begin
      r_com_streak <= '0;
    end
  end
`else
  assign w_com_win = com_req && !reset;
`endif

  assign w_core_win = !reset && !w_com_win && w_pick_any;

  // Grant decode and memory-port mux.
  always_comb begin
    core_grant  = '0;
    com_grant   = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    mem_wr_en   = 1'b0;
    w_gnt_rd    = 1'b0;
    w_gnt_id    = '0;
    if (w_com_win) begin
      com_grant   = 1'b1;
      mem_addr    = com_addr;
      mem_data_in = com_data_in;
      mem_wr_en   = com_wr_en;
      w_gnt_rd    = !com_wr_en;
      w_gnt_id    = ID_W'(NUM_C);
    end else if (w_core_win) begin
      core_grant  = w_pick_gnt;
      mem_addr    = core_addr[32'(w_pick_idx) * ADDR_W +: ADDR_W];
      mem_data_in = core_data_in[32'(w_pick_idx) * DATA_W +: DATA_W];
      mem_wr_en   = core_wr_en[w_pick_idx];
      w_gnt_rd    = !core_wr_en[w_pick_idx];
      w_gnt_id    = ID_W'(w_pick_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_core_win) begin
      r_rr_ptr <= (w_pick_idx == PW'(NUM_C - 1)) ? '0 : w_pick_idx + 1'b1;
    end
  end

  // Read response tag, one cycle behind the grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_id    <= '0;
    end else begin
      r_rd_valid <= w_gnt_rd;
      if (w_gnt_rd) r_rd_id <= w_gnt_id;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_id    = r_rd_id;
  assign rd_data  = mem_data_out;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a registered-read memory model.
// Expectations follow DM_ARB_FAIRNESS_EN when it is defined.
module tb_dm_arbiter;

`ifdef DM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  core_en, core_req, core_wr_en, core_grant;
  logic [63:0] core_addr, core_data_in;
  logic        com_req, com_wr_en, com_grant;
  logic [15:0] com_addr, com_data_in;
  logic [15:0] mem_addr, mem_data_in, mem_data_out;
  logic        mem_wr_en;
  logic        rd_valid;
  logic [2:0]  rd_id;
  logic [15:0] rd_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:255];

  dm_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .core_en      (core_en),
    .core_req     (core_req),
    .core_wr_en   (core_wr_en),
    .core_addr    (core_addr),
    .core_data_in (core_data_in),
    .core_grant   (core_grant),
    .com_req      (com_req),
    .com_wr_en    (com_wr_en),
    .com_addr     (com_addr),
    .com_data_in  (com_data_in),
    .com_grant    (com_grant),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_wr_en    (mem_wr_en),
    .mem_data_out (mem_data_out),
    .rd_valid     (rd_valid),
    .rd_id        (rd_id),
    .rd_data      (rd_data)
  );

  always #5 clk = ~clk;

  // Single-port memory, read data one cycle after address.
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[7:0]] <= mem_data_in;
    mem_data_out <= mem[mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned seq4 [6] = '{0, 1, 3, 0, 1, 3};
    int unsigned prev;
    bit          prev_core;
    bit          exp_core;

    reset = 1'b1; core_en = '0; core_req = '0; core_wr_en = '0;
    core_addr = '0; core_data_in = '0;
    com_req = 1'b0; com_wr_en = 1'b0; com_addr = '0; com_data_in = '0;
    tick(); tick();

    // Grants are suppressed while reset is held.
    core_en = 4'hF; core_req = 4'hF; com_req = 1'b1;
    #1;
    chk("rst_core_grant", 32'(core_grant), 32'h0);
    chk("rst_com_grant", 32'(com_grant), 32'h0);
    chk("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_rd_id", 32'(rd_id), 32'h0);
    com_req = 1'b0;

    // All four cores read continuously: 0,1,2,3,0,1.
    tick();
    reset = 1'b0;
    core_addr = {16'h0023, 16'h0022, 16'h0021, 16'h0020};
    #1;
    for (int c = 0; c < 6; c++) begin
      chk("rr_grant", 32'(core_grant), 32'(1) << (c % 4));
      chk("rr_mem_addr", 32'(mem_addr), 32'h20 + 32'(c % 4));
      chk("rr_wr_en", 32'(mem_wr_en), 32'h0);
      if (c > 0) begin
        chk("rr_rd_valid", 32'(rd_valid), 32'h1);
        chk("rr_rd_id", 32'(rd_id), 32'((c - 1) % 4));
      end
      tick();
    end
    core_req = '0;
    #1;
    chk("rr_last_rd_valid", 32'(rd_valid), 32'h1);
    chk("rr_last_rd_id", 32'(rd_id), 32'h1);
    chk("idle_grant", 32'(core_grant), 32'h0);
    chk("idle_mem_addr", 32'(mem_addr), 32'h0);
    tick();

    // Core 2 writes 0x0010=BEEF, then core 1 reads it back (rr_ptr is 2).
    core_req = 4'b0100; core_wr_en = 4'b0100;
    core_addr = {16'h0033, 16'h0010, 16'h0010, 16'h0000};
    core_data_in = {16'h0000, 16'hBEEF, 16'h0000, 16'h0000};
    #1;
    chk("wr_rd_valid_idle", 32'(rd_valid), 32'h0);
    chk("wr_grant", 32'(core_grant), 32'h4);
    chk("wr_mem_wr_en", 32'(mem_wr_en), 32'h1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h10);
    chk("wr_mem_data", 32'(mem_data_in), 32'hBEEF);
    tick();
    core_req = 4'b0010; core_wr_en = 4'b0000;
    #1;
    chk("rd_grant", 32'(core_grant), 32'h2);
    chk("rd_mem_wr_en", 32'(mem_wr_en), 32'h0);
    chk("rd_mem_addr", 32'(mem_addr), 32'h10);
    chk("wr_no_resp", 32'(rd_valid), 32'h0);
    tick();
    core_req = '0;
    #1;
    chk("rd_valid", 32'(rd_valid), 32'h1);
    chk("rd_id", 32'(rd_id), 32'h1);
    chk("rd_data", 32'(rd_data), 32'hBEEF);
    tick();

    // com held with core 3 waiting.
    core_req = 4'b1000; com_req = 1'b1; com_wr_en = 1'b0; com_addr = 16'h0010;
    #1;
    prev_core = 1'b0;
    for (int c = 0; c < 10; c++) begin
      exp_core = FAIR && (c % 5 == 4);
      if (exp_core) begin
        chk("fair_core_grant", 32'(core_grant), 32'h8);
        chk("fair_com_grant", 32'(com_grant), 32'h0);
        chk("fair_mem_addr", 32'(mem_addr), 32'h33);
      end else begin
        chk("com_grant", 32'(com_grant), 32'h1);
        chk("com_core_grant", 32'(core_grant), 32'h0);
        chk("com_mem_addr", 32'(mem_addr), 32'h10);
      end
      if (c > 0) begin
        chk("com_rd_valid", 32'(rd_valid), 32'h1);
        chk("com_rd_id", 32'(rd_id), prev_core ? 32'h3 : 32'h4);
        if (!prev_core) chk("com_rd_data", 32'(rd_data), 32'hBEEF);
      end
      prev_core = exp_core;
      tick();
    end
    com_req = 1'b0; core_req = '0;
    tick();

    // Reset, then core 2 disabled: 0,1,3,0,1,3.
    reset = 1'b1;
    tick();
    reset = 1'b0; core_en = 4'b1011; core_req = 4'hF;
    core_addr = {16'h0023, 16'h0022, 16'h0021, 16'h0020};
    #1;
    for (int c = 0; c < 6; c++) begin
      prev = seq4[c];
      chk("en_grant", 32'(core_grant), 32'(1) << prev);
      tick();
    end

    // Reset right after a read grant drops the response and rr_ptr.
    core_en = 4'hF; core_req = 4'b0010;
    #1;
    chk("pre_rst_grant", 32'(core_grant), 32'h2);
    tick();
    reset = 1'b1; core_req = 4'hF;
    #1;
    chk("mid_rst_grant", 32'(core_grant), 32'h0);
    chk("mid_rst_wr_en", 32'(mem_wr_en), 32'h0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("post_rst_grant", 32'(core_grant), 32'h1);
    tick();
    core_req = '0;
    #1;
    chk("post_rst_rd_id", 32'(rd_id), 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
